// File: rtl/sync_fifo_read_counter.sv
// ----------------------------------------------------------------------------
// sync_fifo_read_counter
//   Read-side pointer and status controller for an 8-entry synchronous FIFO.
//   The controller gates pop requests against empty and drives the memory read
//   address and strobe. It returns a Gray read pointer to the writer for full
//   detection. It also reports fill level, almost-empty, read-data-valid and a
//   sticky underflow flag.
//
// Ports
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   read_enable         in   pop request from the consumer
//   write_pointer_gray  in   writer's registered Gray pointer (same domain)
//   empty               out  registered FIFO-empty flag
//   almost_empty        out  registered, fill level <= ALMOST_EMPTY_LEVEL
//   read_enable_out     out  combinational memory read strobe
//   read_pointer        out  combinational memory read address
//   read_pointer_gray   out  registered Gray read pointer to the writer
//   fill_level          out  registered word count, 0..2^ADDR_WIDTH
//   data_valid          out  registered, memory read data valid this cycle
//   underflow           out  sticky, set by a pop attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_read_counter #(
  parameter int unsigned ADDR_WIDTH         = 3,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH:0]   write_pointer_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  read_enable_out,
  output logic [ADDR_WIDTH-1:0] read_pointer,
  output logic [ADDR_WIDTH:0]   read_pointer_gray,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  data_valid,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_gray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_fill;
  logic          r_data_valid;
  logic          r_underflow;

  logic          w_pop;
  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_fill_next;
  logic          w_empty_next;
  logic          w_almost_empty_next;

  assign w_pop          = read_enable & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + PW'(w_pop);
  assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

  // Gray-to-binary: prefix XOR running down from the MSB.
  always_comb begin
    w_wr_bin         = '0;
    w_wr_bin[PW-1]   = write_pointer_gray[PW-1];
    for (int unsigned i = 1; i < PW; i++) begin
      w_wr_bin[PW-1-i] = w_wr_bin[PW-i] ^ write_pointer_gray[PW-1-i];
    end
  end

  // Status is computed from the post-pop pointer, so pops are reflected at
  // once while writes show up one cycle late (conservative reader view).
  // The full-width compare keeps the "full" case (MSB differs) out of empty.
  assign w_fill_next         = w_wr_bin - w_rd_bin_next;
  assign w_empty_next        = (w_rd_gray_next == write_pointer_gray);
  assign w_almost_empty_next = (w_fill_next <= PW'(ALMOST_EMPTY_LEVEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_fill         <= '0;
      r_data_valid   <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_gray      <= w_rd_gray_next;
      r_empty        <= w_empty_next;
      r_almost_empty <= w_almost_empty_next;
      r_fill         <= w_fill_next;
      r_data_valid   <= w_pop;
      if (read_enable && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign read_enable_out   = w_pop;
  assign read_pointer      = r_rd_bin[ADDR_WIDTH-1:0];
  assign read_pointer_gray = r_rd_gray;
  assign empty             = r_empty;
  assign almost_empty      = r_almost_empty;
  assign fill_level        = r_fill;
  assign data_valid        = r_data_valid;
  assign underflow         = r_underflow;

endmodule
